// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the 32-bit ALU. It takes a decoded instruction from decode over valid/ready,
// selects operand B, forwards from EX/WB, and registers I/A/B/Rd. It also zeroes illegal ops and counts issues.
module alu_operand_stage #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [3:0]           In_Op,
    input  logic [4:0]           In_RsA_Addr,
    input  logic [4:0]           In_RsB_Addr,
    input  logic [WIDTH-1:0]     In_RsA_Val,
    input  logic [WIDTH-1:0]     In_RsB_Val,
    input  logic [WIDTH-1:0]     In_Imm,
    input  logic                 In_UseImm,
    input  logic [4:0]           In_Rd,
    input  logic                 Fwd_Ex_En,
    input  logic [4:0]           Fwd_Ex_Rd,
    input  logic [WIDTH-1:0]     Fwd_Ex_Data,
    input  logic                 Fwd_Wb_En,
    input  logic [4:0]           Fwd_Wb_Rd,
    input  logic [WIDTH-1:0]     Fwd_Wb_Data,
    input  logic                 Flush,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic [3:0]           I,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [4:0]           Out_Rd,
    output logic                 Out_Illegal,
    output logic [CNT_WIDTH-1:0] Issue_Count,
    output logic [CNT_WIDTH-1:0] Illegal_Count
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_XNOR = 4'hB
    } alu_op_e;

    logic                 valid_q, valid_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [4:0]           rd_q, rd_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] issue_q, issue_d;
    logic [CNT_WIDTH-1:0] illcnt_q, illcnt_d;

    logic             accept;
    logic             drain;
    logic             op_legal;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    assign In_Ready = !valid_q || Out_Ready;
    assign accept   = In_Valid && In_Ready && !Flush;
    assign drain    = valid_q && Out_Ready && !Flush;

    always_comb begin
        op_legal = 1'b0;
        case (alu_op_e'(In_Op))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_XNOR: op_legal = 1'b1;
            default:                                        op_legal = 1'b0;
        endcase
    end

    // EX wins over WB. Register 0 never forwards.
    always_comb begin
        fwd_a = In_RsA_Val;
        if (Fwd_Ex_En && (Fwd_Ex_Rd == In_RsA_Addr) && (In_RsA_Addr != '0)) begin
            fwd_a = Fwd_Ex_Data;
        end else if (Fwd_Wb_En && (Fwd_Wb_Rd == In_RsA_Addr) && (In_RsA_Addr != '0)) begin
            fwd_a = Fwd_Wb_Data;
        end

        fwd_b = In_RsB_Val;
        if (In_UseImm) begin
            fwd_b = In_Imm;
        end else if (Fwd_Ex_En && (Fwd_Ex_Rd == In_RsB_Addr) && (In_RsB_Addr != '0)) begin
            fwd_b = Fwd_Ex_Data;
        end else if (Fwd_Wb_En && (Fwd_Wb_Rd == In_RsB_Addr) && (In_RsB_Addr != '0)) begin
            fwd_b = Fwd_Wb_Data;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        issue_d   = issue_q;
        illcnt_d  = illcnt_q;

        // Flush kills both the held op and any op offered this cycle.
        if (Flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            rd_d      = In_Rd;
            illegal_d = !op_legal;
            op_d      = op_legal ? In_Op : '0;
            a_d       = op_legal ? fwd_a : '0;
            b_d       = op_legal ? fwd_b : '0;
        end else if (drain) begin
            valid_d = 1'b0;
        end

        if (drain) begin
            issue_d = issue_q + CNT_WIDTH'(1);
            if (illegal_q) begin
                illcnt_d = illcnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            issue_q   <= '0;
            illcnt_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
            issue_q   <= issue_d;
            illcnt_q  <= illcnt_d;
        end
    end

    assign Out_Valid     = valid_q;
    assign I             = op_q;
    assign A             = a_q;
    assign B             = b_q;
    assign Out_Rd        = rd_q;
    assign Out_Illegal   = illegal_q;
    assign Issue_Count   = issue_q;
    assign Illegal_Count = illcnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage. A second instance with 2-bit counters shares the
// stimulus so that counter wrap can be checked against the same issue history.
module tb_alu_operand_stage;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        In_Valid;
    logic [3:0]  In_Op;
    logic [4:0]  In_RsA_Addr, In_RsB_Addr, In_Rd;
    logic [31:0] In_RsA_Val, In_RsB_Val, In_Imm;
    logic        In_UseImm;
    logic        Fwd_Ex_En, Fwd_Wb_En;
    logic [4:0]  Fwd_Ex_Rd, Fwd_Wb_Rd;
    logic [31:0] Fwd_Ex_Data, Fwd_Wb_Data;
    logic        Flush;
    logic        Out_Ready;

    logic        In_Ready, Out_Valid, Out_Illegal;
    logic [3:0]  I;
    logic [31:0] A, B;
    logic [4:0]  Out_Rd;
    logic [15:0] Issue_Count, Illegal_Count;

    logic        w_In_Ready, w_Out_Valid, w_Out_Illegal;
    logic [3:0]  w_I;
    logic [31:0] w_A, w_B;
    logic [4:0]  w_Out_Rd;
    logic [1:0]  w_Issue_Count, w_Illegal_Count;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    alu_operand_stage #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Op(In_Op), .In_RsA_Addr(In_RsA_Addr), .In_RsB_Addr(In_RsB_Addr),
        .In_RsA_Val(In_RsA_Val), .In_RsB_Val(In_RsB_Val), .In_Imm(In_Imm),
        .In_UseImm(In_UseImm), .In_Rd(In_Rd),
        .Fwd_Ex_En(Fwd_Ex_En), .Fwd_Ex_Rd(Fwd_Ex_Rd), .Fwd_Ex_Data(Fwd_Ex_Data),
        .Fwd_Wb_En(Fwd_Wb_En), .Fwd_Wb_Rd(Fwd_Wb_Rd), .Fwd_Wb_Data(Fwd_Wb_Data),
        .Flush(Flush), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .I(I), .A(A), .B(B), .Out_Rd(Out_Rd), .Out_Illegal(Out_Illegal),
        .Issue_Count(Issue_Count), .Illegal_Count(Illegal_Count)
    );

    alu_operand_stage #(.WIDTH(32), .CNT_WIDTH(2)) u_wrap (
        .Clk(Clk), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(w_In_Ready),
        .In_Op(In_Op), .In_RsA_Addr(In_RsA_Addr), .In_RsB_Addr(In_RsB_Addr),
        .In_RsA_Val(In_RsA_Val), .In_RsB_Val(In_RsB_Val), .In_Imm(In_Imm),
        .In_UseImm(In_UseImm), .In_Rd(In_Rd),
        .Fwd_Ex_En(Fwd_Ex_En), .Fwd_Ex_Rd(Fwd_Ex_Rd), .Fwd_Ex_Data(Fwd_Ex_Data),
        .Fwd_Wb_En(Fwd_Wb_En), .Fwd_Wb_Rd(Fwd_Wb_Rd), .Fwd_Wb_Data(Fwd_Wb_Data),
        .Flush(Flush), .Out_Valid(w_Out_Valid), .Out_Ready(Out_Ready),
        .I(w_I), .A(w_A), .B(w_B), .Out_Rd(w_Out_Rd), .Out_Illegal(w_Out_Illegal),
        .Issue_Count(w_Issue_Count), .Illegal_Count(w_Illegal_Count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [4:0] ra, input logic [4:0] rb,
                            input logic [31:0] va, input logic [31:0] vb,
                            input logic use_imm, input logic [31:0] imm, input logic [4:0] rd);
        In_Valid    = 1'b1;
        In_Op       = op;
        In_RsA_Addr = ra;
        In_RsB_Addr = rb;
        In_RsA_Val  = va;
        In_RsB_Val  = vb;
        In_UseImm   = use_imm;
        In_Imm      = imm;
        In_Rd       = rd;
    endtask

    task automatic set_fwd(input logic ex_en, input logic [4:0] ex_rd, input logic [31:0] ex_d,
                           input logic wb_en, input logic [4:0] wb_rd, input logic [31:0] wb_d);
        Fwd_Ex_En = ex_en; Fwd_Ex_Rd = ex_rd; Fwd_Ex_Data = ex_d;
        Fwd_Wb_En = wb_en; Fwd_Wb_Rd = wb_rd; Fwd_Wb_Data = wb_d;
    endtask

    initial begin
        Reset_n = 1'b0;
        In_Valid = 1'b0; Flush = 1'b0; Out_Ready = 1'b0;
        drive_op(4'h0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 5'd0);
        In_Valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (3) step();
        check("rst_valid", {31'd0, Out_Valid}, 32'd0);
        check("rst_ready", {31'd0, In_Ready}, 32'd1);
        check("rst_issue", {16'd0, Issue_Count}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step();

        // Back-to-back issue: 4 ops, no bubbles.
        Out_Ready = 1'b1;
        drive_op(4'h0, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 32'd0, 5'd4);
        step();
        check("t2_v1", {31'd0, Out_Valid}, 32'd1);
        check("t2_i1", {28'd0, I}, 32'h0);
        check("t2_a1", A, 32'd5);
        check("t2_b1", B, 32'd7);
        check("t2_rd1", {27'd0, Out_Rd}, 32'd4);
        drive_op(4'h1, 5'd1, 5'd2, 32'd10, 32'd3, 1'b0, 32'd0, 5'd5);
        step();
        check("t2_i2", {28'd0, I}, 32'h1);
        check("t2_a2", A, 32'd10);
        check("t2_cnt1", {16'd0, Issue_Count}, 32'd1);
        drive_op(4'h8, 5'd1, 5'd2, 32'hF0F0, 32'h0FF0, 1'b0, 32'd0, 5'd6);
        step();
        check("t2_i3", {28'd0, I}, 32'h8);
        check("t2_b3", B, 32'h0FF0);
        drive_op(4'h9, 5'd1, 5'd2, 32'h1, 32'h2, 1'b0, 32'd0, 5'd7);
        step();
        check("t2_i4", {28'd0, I}, 32'h9);
        check("t2_v4", {31'd0, Out_Valid}, 32'd1);
        check("t2_cnt3", {16'd0, Issue_Count}, 32'd3);
        In_Valid = 1'b0;
        step();
        check("t2_drained", {31'd0, Out_Valid}, 32'd0);
        check("t2_cnt4", {16'd0, Issue_Count}, 32'd4);
        check("t2_wrap4", {30'd0, w_Issue_Count}, 32'd0);
        check("t2_wrap_valid", {31'd0, w_Out_Valid}, 32'd0);

        // Forwarding priority and register-0 exclusion.
        set_fwd(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        drive_op(4'h0, 5'd3, 5'd2, 32'h99, 32'h1, 1'b0, 32'd0, 5'd1);
        step();
        check("t3_ex", A, 32'h11);
        set_fwd(1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
        step();
        check("t3_wb", A, 32'h22);
        set_fwd(1'b1, 5'd0, 32'h33, 1'b1, 5'd0, 32'h55);
        drive_op(4'h0, 5'd0, 5'd2, 32'h44, 32'h1, 1'b0, 32'd0, 5'd1);
        step();
        check("t3_r0", A, 32'h44);
        set_fwd(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'h0);
        drive_op(4'h0, 5'd1, 5'd3, 32'h1, 32'h2, 1'b1, 32'hFFFFFFFC, 5'd1);
        step();
        check("t3_imm", B, 32'hFFFFFFFC);
        drive_op(4'h0, 5'd1, 5'd3, 32'h1, 32'h2, 1'b0, 32'hFFFFFFFC, 5'd1);
        step();
        check("t3_fwd_b", B, 32'h11);
        In_Valid = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step();
        check("t3_cnt", {16'd0, Issue_Count}, 32'd9);

        // Backpressure: held op stays stable, the next op waits.
        Out_Ready = 1'b0;
        drive_op(4'hA, 5'd1, 5'd2, 32'hF0, 32'h0F, 1'b0, 32'd0, 5'd5);
        step();
        check("t4_i", {28'd0, I}, 32'hA);
        drive_op(4'h9, 5'd1, 5'd2, 32'h100, 32'h200, 1'b0, 32'd0, 5'd6);
        set_fwd(1'b1, 5'd1, 32'hDEAD, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_hold_a", A, 32'hF0);
            check("t4_hold_i", {28'd0, I}, 32'hA);
            check("t4_in_ready", {31'd0, In_Ready}, 32'd0);
        end
        check("t4_cnt_hold", {16'd0, Issue_Count}, 32'd9);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        Out_Ready = 1'b1;
        step();
        check("t4_next_i", {28'd0, I}, 32'h9);
        check("t4_next_a", A, 32'h100);
        In_Valid = 1'b0;
        step();
        check("t4_cnt", {16'd0, Issue_Count}, 32'd11);

        // Illegal op is zeroed but still counted.
        drive_op(4'h5, 5'd1, 5'd2, 32'h123, 32'h456, 1'b0, 32'd0, 5'd9);
        step();
        check("t5_illegal", {31'd0, Out_Illegal}, 32'd1);
        check("t5_i", {28'd0, I}, 32'h0);
        check("t5_a", A, 32'h0);
        check("t5_b", B, 32'h0);
        check("t5_rd", {27'd0, Out_Rd}, 32'd9);
        In_Valid = 1'b0;
        step();
        check("t5_illcnt", {16'd0, Illegal_Count}, 32'd1);
        check("t5_issue", {16'd0, Issue_Count}, 32'd12);

        // Flush drops the held op and the one offered in the same cycle.
        Out_Ready = 1'b0;
        drive_op(4'h0, 5'd1, 5'd2, 32'h7, 32'h8, 1'b0, 32'd0, 5'd2);
        step();
        check("t6_held", {31'd0, Out_Valid}, 32'd1);
        check("t6_legal", {31'd0, Out_Illegal}, 32'd0);
        drive_op(4'h1, 5'd1, 5'd2, 32'h9, 32'h3, 1'b0, 32'd0, 5'd3);
        Out_Ready = 1'b1;
        Flush = 1'b1;
        step();
        check("t6_flush_valid", {31'd0, Out_Valid}, 32'd0);
        check("t6_flush_cnt", {16'd0, Issue_Count}, 32'd12);
        Flush = 1'b0;
        In_Valid = 1'b0;
        step();
        check("t6_dropped", {31'd0, Out_Valid}, 32'd0);
        check("t6_illcnt", {16'd0, Illegal_Count}, 32'd1);

        // Five more issues: 17 total, narrow counter reads 17 mod 4 = 1.
        for (int k = 0; k < 5; k++) begin
            drive_op(4'hB, 5'd1, 5'd2, 32'(k), 32'h0, 1'b0, 32'd0, 5'd1);
            step();
        end
        In_Valid = 1'b0;
        step();
        check("t6_wrap", {30'd0, w_Issue_Count}, 32'd1);
        check("t6_wide", {16'd0, Issue_Count}, 32'd17);
        check("t6_wrap_ill", {30'd0, w_Illegal_Count}, 32'd1);

        // Mid-operation reset discards the in-flight op and clears counters.
        Out_Ready = 1'b0;
        drive_op(4'h8, 5'd1, 5'd2, 32'hAB, 32'hCD, 1'b0, 32'd0, 5'd8);
        step();
        check("t1_inflight", {31'd0, Out_Valid}, 32'd1);
        Reset_n = 1'b0;
        #1;
        check("t1_valid", {31'd0, Out_Valid}, 32'd0);
        check("t1_i", {28'd0, I}, 32'h0);
        check("t1_a", A, 32'h0);
        check("t1_b", B, 32'h0);
        check("t1_issue", {16'd0, Issue_Count}, 32'd0);
        check("t1_illcnt", {16'd0, Illegal_Count}, 32'd0);
        check("t1_ready", {31'd0, In_Ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
